// File: rtl/wb_commit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wb_commit_pkg
//  Purpose  : Shared regfile geometry and load-queue entry type for the
//             write-back / commit stage.
//  Revision : 1.0  initial release
// ============================================================================
package wb_commit_pkg;

    localparam int c_REG_AW  = 5;   // regfile address width
    localparam int c_GPR_NUM = 32;  // number of general-purpose registers

    // One pending load: destination register and whether its result is dead
    typedef struct packed {
        logic [c_REG_AW-1:0] rd;
        logic                kill;
    } lq_entry_t;

    // Onehot decode of a register number into a GPR-wide mask
    function automatic logic [c_GPR_NUM-1:0] f_onehot(input logic [c_REG_AW-1:0] rd);
        f_onehot     = '0;
        f_onehot[rd] = 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_load_queue.sv
`default_nettype none
// ============================================================================
//  Module   : wb_load_queue
//  Purpose  : In-order circular queue of pending loads. Entries are marked
//             dead by a flush or by a younger ALU write to the same register;
//             dead entries still pop when their dcache response arrives.
//             Publishes a registered mask of registers owned by live loads.
//  Revision : 1.0  initial release
// ============================================================================
module wb_load_queue
    import wb_commit_pkg::*;
#(
    parameter int LQ_DEPTH = 2
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_push,
    input  logic [c_REG_AW-1:0]  i_push_rd,
    input  logic                 i_push_kill,
    input  logic                 i_pop,        // only asserted when non-empty
    input  logic                 i_kill0_en,
    input  logic [c_REG_AW-1:0]  i_kill0_rd,
    input  logic                 i_kill1_en,
    input  logic [c_REG_AW-1:0]  i_kill1_rd,
    output lq_entry_t            o_head,
    output logic                 o_empty,
    output logic                 o_full,
    output logic [c_GPR_NUM-1:0] o_live_mask
);

    localparam int c_PTR_W = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int c_CNT_W = c_PTR_W + 1;

    lq_entry_t              r_ent [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]    r_vld;
    logic [c_PTR_W-1:0]     r_head;
    logic [c_PTR_W-1:0]     r_tail;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_GPR_NUM-1:0]   r_live_mask;

    lq_entry_t              w_ent_nxt [LQ_DEPTH];
    logic [LQ_DEPTH-1:0]    w_vld_nxt;
    logic [c_GPR_NUM-1:0]   w_mask_nxt;

    assign o_head      = r_ent[r_head];
    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == c_CNT_W'(LQ_DEPTH));
    assign o_live_mask = r_live_mask;

    // Next entry contents: apply kills to resident entries, then pop and push
    always_comb begin
        w_ent_nxt  = r_ent;
        w_vld_nxt  = r_vld;
        w_mask_nxt = '0;
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (i_flush ||
                (i_kill0_en && (r_ent[i].rd == i_kill0_rd)) ||
                (i_kill1_en && (r_ent[i].rd == i_kill1_rd))) begin
                w_ent_nxt[i].kill = 1'b1;
            end
        end
        if (i_pop) begin
            w_vld_nxt[r_head] = 1'b0;
        end
        if (i_push) begin
            w_vld_nxt[r_tail]      = 1'b1;
            w_ent_nxt[r_tail].rd   = i_push_rd;
            w_ent_nxt[r_tail].kill = i_push_kill;
        end
        for (int i = 0; i < LQ_DEPTH; i++) begin
            if (w_vld_nxt[i] && !w_ent_nxt[i].kill) begin
                w_mask_nxt = w_mask_nxt | f_onehot(w_ent_nxt[i].rd);
            end
        end
        w_mask_nxt[0] = 1'b0;
    end

    // Queue state register; pointers wrap naturally at the power-of-2 depth
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld       <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_live_mask <= '0;
            for (int i = 0; i < LQ_DEPTH; i++) begin
                r_ent[i] <= '0;
            end
        end else begin
            r_ent       <= w_ent_nxt;
            r_vld       <= w_vld_nxt;
            r_head      <= r_head + c_PTR_W'(i_pop);
            r_tail      <= r_tail + c_PTR_W'(i_push);
            r_count     <= r_count + c_CNT_W'(i_push) - c_CNT_W'(i_pop);
            r_live_mask <= w_mask_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_commit.sv
`default_nettype none
// ============================================================================
//  Module   : wb_commit
//  Purpose  : Write-back / commit stage. Commits slot 0/1 ALU results one
//             cycle after the EX handshake, commits returning load data on
//             port 2 in order, resolves WAW and port collisions, and keeps
//             the load-use busy mask and retired-instruction counter.
//  Revision : 1.0  initial release
// ============================================================================
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int LQ_DEPTH = 2,
    parameter int CNT_W    = 32
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 ex_valid,
    output logic                 wb_allowin,
    input  logic                 ex_we0,
    input  logic                 ex_we1,
    input  logic [c_REG_AW-1:0]  ex_rd0,
    input  logic [c_REG_AW-1:0]  ex_rd1,
    input  logic [31:0]          ex_data0,
    input  logic [31:0]          ex_data1,
    input  logic                 ex_is_load0,
    input  logic                 dcache_rready,
    input  logic [31:0]          dcache_rdata,
    output logic                 we_0,
    output logic                 we_1,
    output logic                 we_2,
    output logic [c_REG_AW-1:0]  wb_rd0,
    output logic [c_REG_AW-1:0]  wb_rd1,
    output logic [c_REG_AW-1:0]  wb_rd2,
    output logic [31:0]          rd0_data,
    output logic [31:0]          rd1_data,
    output logic [31:0]          rd2_data,
    output logic [c_GPR_NUM-1:0] busy_mask,
    output logic [CNT_W-1:0]     retire_cnt,
    output logic                 lq_err
);

    logic                 w_accept;
    logic                 w_alu0;
    logic                 w_alu1;
    logic                 w_waw;
    logic                 w_we0;
    logic                 w_we1;
    logic                 w_we2;
    logic                 w_push;
    logic                 w_push_kill;
    logic                 w_pop;
    logic                 w_collide;
    logic                 w_kill0_en;
    logic                 w_kill1_en;
    logic                 w_lq_empty;
    logic                 w_lq_full;
    lq_entry_t            w_head;
    logic [c_GPR_NUM-1:0] w_live_mask;
    logic [1:0]           w_retire_inc;

    // Back-pressure uses only the registered occupancy, never a same-cycle pop
    assign wb_allowin  = ~w_lq_full;
    assign w_accept    = ex_valid & wb_allowin & ~flush;

    assign w_alu0      = ex_we0 & ~ex_is_load0 & (|ex_rd0);
    assign w_alu1      = ex_we1 & (|ex_rd1);
    // Younger slot 1 wins a same-bundle write to the same register
    assign w_waw       = w_alu0 & w_alu1 & (ex_rd0 == ex_rd1);
    assign w_we0       = w_accept & w_alu0 & ~w_waw;
    assign w_we1       = w_accept & w_alu1;

    // Any accepted ALU write kills older queued loads to the same register
    assign w_kill0_en  = w_accept & w_alu0;
    assign w_kill1_en  = w_accept & w_alu1;

    // A load whose slot-1 partner writes the same register is born dead
    assign w_push      = w_accept & ex_is_load0 & ex_we0 & (|ex_rd0);
    assign w_push_kill = w_alu1 & (ex_rd1 == ex_rd0);

    assign w_pop       = dcache_rready & ~w_lq_empty;
    assign w_collide   = (w_kill0_en & (ex_rd0 == w_head.rd)) |
                         (w_kill1_en & (ex_rd1 == w_head.rd));
    assign w_we2       = w_pop & ~w_head.kill & ~flush & ~w_collide;

    assign w_retire_inc = w_accept ? (2'd1 + {1'b0, ex_we1 | ~ex_we0}) : 2'd0;
    assign busy_mask    = w_live_mask;

    wb_load_queue #(
        .LQ_DEPTH    (LQ_DEPTH)
    ) u_lq (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (flush),
        .i_push      (w_push),
        .i_push_rd   (ex_rd0),
        .i_push_kill (w_push_kill),
        .i_pop       (w_pop),
        .i_kill0_en  (w_kill0_en),
        .i_kill0_rd  (ex_rd0),
        .i_kill1_en  (w_kill1_en),
        .i_kill1_rd  (ex_rd1),
        .o_head      (w_head),
        .o_empty     (w_lq_empty),
        .o_full      (w_lq_full),
        .o_live_mask (w_live_mask)
    );

    // Commit registers: single-cycle write pulses plus address/data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            we_0       <= 1'b0;
            we_1       <= 1'b0;
            we_2       <= 1'b0;
            wb_rd0     <= '0;
            wb_rd1     <= '0;
            wb_rd2     <= '0;
            rd0_data   <= '0;
            rd1_data   <= '0;
            rd2_data   <= '0;
            retire_cnt <= '0;
            lq_err     <= 1'b0;
        end else begin
            we_0 <= w_we0;
            we_1 <= w_we1;
            we_2 <= w_we2;
            if (w_accept) begin
                wb_rd0   <= ex_rd0;
                rd0_data <= ex_data0;
                wb_rd1   <= ex_rd1;
                rd1_data <= ex_data1;
            end
            if (w_pop) begin
                wb_rd2   <= w_head.rd;
                rd2_data <= dcache_rdata;
            end
            retire_cnt <= retire_cnt + CNT_W'(w_retire_inc);
            lq_err     <= lq_err | (dcache_rready & w_lq_empty);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_commit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_commit
//  Purpose  : Self-checking bench for wb_commit: directed scenarios with
//             literal expectations, then randomized traffic compared every
//             cycle against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_commit;

    localparam int LQ_DEPTH = 2;
    localparam int CNT_W    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ex_valid;
    logic        wb_allowin;
    logic        ex_we0, ex_we1;
    logic [4:0]  ex_rd0, ex_rd1;
    logic [31:0] ex_data0, ex_data1;
    logic        ex_is_load0;
    logic        dcache_rready;
    logic [31:0] dcache_rdata;
    logic        we_0, we_1, we_2;
    logic [4:0]  wb_rd0, wb_rd1, wb_rd2;
    logic [31:0] rd0_data, rd1_data, rd2_data;
    logic [31:0] busy_mask;
    logic [CNT_W-1:0] retire_cnt;
    logic        lq_err;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    wb_commit #(.LQ_DEPTH(LQ_DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_valid(ex_valid), .wb_allowin(wb_allowin),
        .ex_we0(ex_we0), .ex_we1(ex_we1), .ex_rd0(ex_rd0), .ex_rd1(ex_rd1),
        .ex_data0(ex_data0), .ex_data1(ex_data1), .ex_is_load0(ex_is_load0),
        .dcache_rready(dcache_rready), .dcache_rdata(dcache_rdata),
        .we_0(we_0), .we_1(we_1), .we_2(we_2),
        .wb_rd0(wb_rd0), .wb_rd1(wb_rd1), .wb_rd2(wb_rd2),
        .rd0_data(rd0_data), .rd1_data(rd1_data), .rd2_data(rd2_data),
        .busy_mask(busy_mask), .retire_cnt(retire_cnt), .lq_err(lq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: pending loads as a plain queue ----------
    typedef struct {
        logic [4:0] rd;
        bit         dead;
    } ld_t;

    ld_t         mq[$];
    logic        e_we0, e_we1, e_we2, e_err, e_allow;
    logic [4:0]  e_rd0, e_rd1, e_rd2;
    logic [31:0] e_d0, e_d1, e_d2, e_busy;
    logic [31:0] e_ret;

    always @(posedge clk) begin : p_model
        bit         acc, a0, a1, w0, w1, w2, err;
        ld_t        h;
        logic [31:0] busy;
        w0 = 0; w1 = 0; w2 = 0; err = 0; busy = 0;
        if (rst) begin
            mq.delete();
            e_we0 <= 0; e_we1 <= 0; e_we2 <= 0; e_err <= 0; e_allow <= 1;
            e_rd0 <= 0; e_rd1 <= 0; e_rd2 <= 0; e_d0 <= 0; e_d1 <= 0; e_d2 <= 0;
            e_busy <= 0; e_ret <= 0;
        end else begin
            acc = ex_valid && (mq.size() < LQ_DEPTH) && !flush;
            a0  = ex_we0 && !ex_is_load0 && (ex_rd0 != 0);
            a1  = ex_we1 && (ex_rd1 != 0);
            if (acc) begin
                w1 = a1;
                w0 = a0 && !(a1 && ex_rd1 == ex_rd0);
                e_rd0 <= ex_rd0; e_d0 <= ex_data0;
                e_rd1 <= ex_rd1; e_d1 <= ex_data1;
                e_ret <= e_ret + 1 + ((ex_we1 || !ex_we0) ? 1 : 0);
            end
            if (dcache_rready) begin
                if (mq.size() == 0) begin
                    err = 1;
                end else begin
                    h  = mq.pop_front();
                    w2 = !h.dead && !flush &&
                         !(acc && ((a0 && ex_rd0 == h.rd) || (a1 && ex_rd1 == h.rd)));
                    e_rd2 <= h.rd; e_d2 <= dcache_rdata;
                end
            end
            foreach (mq[i]) begin
                if (flush) mq[i].dead = 1;
                if (acc && a0 && mq[i].rd == ex_rd0) mq[i].dead = 1;
                if (acc && a1 && mq[i].rd == ex_rd1) mq[i].dead = 1;
            end
            if (acc && ex_is_load0 && ex_we0 && ex_rd0 != 0) begin
                h.rd   = ex_rd0;
                h.dead = a1 && (ex_rd1 == ex_rd0);
                mq.push_back(h);
            end
            foreach (mq[i]) if (!mq[i].dead) busy[mq[i].rd] = 1'b1;
            e_we0 <= w0; e_we1 <= w1; e_we2 <= w2;
            e_err <= e_err | err;
            e_busy <= busy;
            e_allow <= (mq.size() < LQ_DEPTH);
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_we_0", {31'd0, we_0}, {31'd0, e_we0});
            chk("m_we_1", {31'd0, we_1}, {31'd0, e_we1});
            chk("m_we_2", {31'd0, we_2}, {31'd0, e_we2});
            if (e_we0) begin chk("m_wb_rd0", {27'd0, wb_rd0}, {27'd0, e_rd0}); chk("m_rd0_data", rd0_data, e_d0); end
            if (e_we1) begin chk("m_wb_rd1", {27'd0, wb_rd1}, {27'd0, e_rd1}); chk("m_rd1_data", rd1_data, e_d1); end
            if (e_we2) begin chk("m_wb_rd2", {27'd0, wb_rd2}, {27'd0, e_rd2}); chk("m_rd2_data", rd2_data, e_d2); end
            chk("m_busy_mask", busy_mask, e_busy);
            chk("m_retire_cnt", retire_cnt, e_ret);
            chk("m_lq_err", {31'd0, lq_err}, {31'd0, e_err});
            chk("m_wb_allowin", {31'd0, wb_allowin}, {31'd0, e_allow});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        flush = 0; ex_valid = 0; ex_we0 = 0; ex_we1 = 0; ex_rd0 = 0; ex_rd1 = 0;
        ex_data0 = 0; ex_data1 = 0; ex_is_load0 = 0; dcache_rready = 0; dcache_rdata = 0;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic load(input logic [4:0] rd);
        idle(); ex_valid = 1; ex_we0 = 1; ex_is_load0 = 1; ex_rd0 = rd;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (3) step();
        rst = 0;
        chk_en = 1;
        // reset state
        chk("rst_we", {29'd0, we_0, we_1, we_2}, 32'd0);
        chk("rst_busy", busy_mask, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        chk("rst_lq_err", {31'd0, lq_err}, 32'd0);
        chk("rst_allowin", {31'd0, wb_allowin}, 32'd1);

        // 1: ALU pair
        idle(); ex_valid = 1; ex_we0 = 1; ex_rd0 = 3; ex_data0 = 32'h11;
        ex_we1 = 1; ex_rd1 = 4; ex_data1 = 32'h22;
        step();
        chk("t1_we01", {30'd0, we_0, we_1}, 32'd3);
        chk("t1_rd0", {27'd0, wb_rd0}, 32'd3);
        chk("t1_rd1", {27'd0, wb_rd1}, 32'd4);
        chk("t1_data0", rd0_data, 32'h11);
        chk("t1_retire", retire_cnt, 32'd2);

        // 2: same-bundle WAW
        idle(); ex_valid = 1; ex_we0 = 1; ex_rd0 = 5; ex_data0 = 32'hA;
        ex_we1 = 1; ex_rd1 = 5; ex_data1 = 32'hB;
        step();
        chk("t2_we01", {30'd0, we_0, we_1}, 32'd1);
        chk("t2_data1", rd1_data, 32'hB);
        chk("t2_retire", retire_cnt, 32'd4);

        // 3: load then younger ALU write to the same register
        load(7);
        step();
        chk("t3_busy_load", busy_mask, 32'h80);
        chk("t3_retire", retire_cnt, 32'd5);
        idle(); ex_valid = 1; ex_we0 = 1; ex_rd0 = 7; ex_data0 = 32'h55;
        step();
        chk("t3_we0", {31'd0, we_0}, 32'd1);
        chk("t3_busy_killed", busy_mask, 32'h0);
        idle(); dcache_rready = 1; dcache_rdata = 32'h99;
        step();
        chk("t3_we2_stale", {31'd0, we_2}, 32'd0);
        chk("t3_lq_err", {31'd0, lq_err}, 32'd0);

        // 4: fill the queue, back-pressure, in-order return; 6: push+pop at count 1
        load(8); step();
        load(9); step();
        chk("t4_allow_full", {31'd0, wb_allowin}, 32'd0);
        chk("t4_busy", busy_mask, 32'h300);
        load(10); dcache_rready = 1; dcache_rdata = 32'h88;
        step();
        chk("t4_we2_r8", {26'd0, we_2, wb_rd2}, {26'd0, 1'b1, 5'd8});
        chk("t4_data_r8", rd2_data, 32'h88);
        chk("t4_allow_free", {31'd0, wb_allowin}, 32'd1);
        chk("t4_retire", retire_cnt, 32'd8);
        load(10); dcache_rready = 1; dcache_rdata = 32'h99;
        step();
        chk("t6_we2_r9", {26'd0, we_2, wb_rd2}, {26'd0, 1'b1, 5'd9});
        chk("t6_busy", busy_mask, 32'h400);
        chk("t6_allow", {31'd0, wb_allowin}, 32'd1);
        idle(); dcache_rready = 1; dcache_rdata = 32'h10;
        step();
        chk("t6_we2_r10", {26'd0, we_2, wb_rd2}, {26'd0, 1'b1, 5'd10});
        chk("t6_data_r10", rd2_data, 32'h10);

        // 5: flush with two queued loads
        load(11); step();
        load(12); step();
        idle(); flush = 1; ex_valid = 1; ex_we0 = 1; ex_rd0 = 11; ex_data0 = 32'h77;
        step();
        chk("t5_busy_flush", busy_mask, 32'h0);
        chk("t5_no_write", {31'd0, we_0}, 32'd0);
        chk("t5_retire", retire_cnt, 32'd11);
        idle(); dcache_rready = 1; dcache_rdata = 32'h1;
        step();
        chk("t5_we2_a", {31'd0, we_2}, 32'd0);
        step();
        chk("t5_we2_b", {31'd0, we_2}, 32'd0);
        chk("t5_lq_err", {31'd0, lq_err}, 32'd0);
        // 6: stray response on empty queue
        step();
        chk("t6_stray_err", {31'd0, lq_err}, 32'd1);
        chk("t6_stray_we2", {31'd0, we_2}, 32'd0);

        // randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            idle();
            rst           = ($urandom_range(0, 299) == 0);
            flush         = ($urandom_range(0, 15) == 0);
            ex_valid      = $urandom_range(0, 1);
            ex_we0        = ($urandom_range(0, 3) != 0);
            ex_we1        = ($urandom_range(0, 3) != 0);
            ex_is_load0   = ($urandom_range(0, 2) == 0);
            ex_rd0        = 5'($urandom_range(0, 7));
            ex_rd1        = 5'($urandom_range(0, 7));
            ex_data0      = $urandom;
            ex_data1      = $urandom;
            dcache_rready = ($urandom_range(0, 2) == 0);
            dcache_rdata  = $urandom;
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
